alu_exec_ctrl: RTL

- Execution-side partner of the ALU: supplies `instruction`, `rddata`, `rsdata`, `carrystatus`, `skipstatus` and `exec1`; consumes `aluout`, `carryout`, `skipout`, `carryen`, `skipen`, `wenout`.
- Holds IR', the 4x16 register file, and the CARRY and SKIP flip-flops.
- A two-state timing machine accepts one instruction per fetch handshake, then runs one EXEC1 cycle in which all ALU-requested writes commit.
- Sits between instruction memory and the ALU.

---
 rtl/cpu_pkg.sv | 25 ++
 rtl/alu_exec_ctrl_if.sv | 33 +++
 rtl/alu_regfile.sv | 34 +++
 rtl/alu_exec_ctrl.sv | 93 +++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the ALU execution controller: FSM encoding,
// instruction field layout and register-file geometry.
package cpu_pkg;

  typedef enum logic {
    ST_FETCH = 1'b0,
    ST_EXEC1 = 1'b1
  } state_t;

  // Field layout of IR': CODE 15:14, CIN 13:12, COND 11:8, CW 7, OP 6:4, RD 3:2, RS 1:0
  typedef struct packed {
    logic [1:0] code;
    logic [1:0] cin;
    logic [3:0] cond;
    logic       cw;
    logic [2:0] op;
    logic [1:0] rd;
    logic [1:0] rs;
  } instr_t;

  localparam logic [1:0] ARM_CODE = 2'b11;
  localparam int         NUM_REGS = 4;
  localparam int         REG_W    = 16;

endpackage

// File: rtl/alu_exec_ctrl_if.sv
// Fetch handshake plus ALU-facing bus of the execution controller.
interface alu_exec_ctrl_if;
  // Fetch handshake: an instruction transfers on a rising edge where
  // instr_valid and instr_ready are both high; instr_in must be stable while
  // instr_valid is high, and instr_ready does not depend on instr_valid.
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr_in;

  logic [15:0] instruction;
  logic [15:0] rddata;
  logic [15:0] rsdata;
  logic        carrystatus;
  logic        skipstatus;
  logic        exec1;

  logic [15:0] aluout;
  logic        carryout;
  logic        skipout;
  logic        carryen;
  logic        skipen;
  logic        wenout;

  modport master (
    input  instr_valid, instr_in, aluout, carryout, skipout, carryen, skipen, wenout,
    output instr_ready, instruction, rddata, rsdata, carrystatus, skipstatus, exec1
  );

  modport slave (
    output instr_valid, instr_in, aluout, carryout, skipout, carryen, skipen, wenout,
    input  instr_ready, instruction, rddata, rsdata, carrystatus, skipstatus, exec1
  );
endinterface

// File: rtl/alu_regfile.sv
// 4x16 register file: three asynchronous read ports, one synchronous write
// port, asynchronously cleared.
module alu_regfile
  import cpu_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             we,
  input  logic [1:0]       waddr,
  input  logic [REG_W-1:0] wdata,
  input  logic [1:0]       raddr_a,
  output logic [REG_W-1:0] rdata_a,
  input  logic [1:0]       raddr_b,
  output logic [REG_W-1:0] rdata_b,
  input  logic [1:0]       raddr_c,
  output logic [REG_W-1:0] rdata_c
);

  logic [REG_W-1:0] regs [NUM_REGS];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  // Reads return pre-write data; a write only shows up after its edge.
  assign rdata_a = regs[raddr_a];
  assign rdata_b = regs[raddr_b];
  assign rdata_c = regs[raddr_c];

endmodule

// File: rtl/alu_exec_ctrl.sv
// Execution controller beside the ALU: holds IR', the register file and the
// CARRY/SKIP flags, and sequences FETCH -> EXEC1 for each instruction.
module alu_exec_ctrl
  import cpu_pkg::*;
#(
  parameter logic [15:0] RESET_IR = 16'h0000,
  parameter int          CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  alu_exec_ctrl_if.master   bus,
  output logic [CNT_W-1:0]  retired,
  input  logic [1:0]        dbg_addr,
  output logic [15:0]       dbg_data,
  output logic              proto_err,
  output state_t            dbg_state
);

  state_t      state, state_nxt;
  logic [15:0] ir;
  instr_t      ir_f;
  logic        carry_q, skip_q;
  logic        accept;
  logic        any_en;

  assign ir_f   = instr_t'(ir);
  assign accept = bus.instr_valid && bus.instr_ready;
  assign any_en = bus.carryen || bus.skipen || bus.wenout;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_FETCH;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_FETCH: if (accept) state_nxt = ST_EXEC1;
      ST_EXEC1: state_nxt = ST_FETCH;
      default:  state_nxt = ST_FETCH;
    endcase
  end

  always_comb begin
    bus.instr_ready = 1'b0;
    bus.exec1       = 1'b0;
    case (state)
      ST_FETCH: bus.instr_ready = 1'b1;
      ST_EXEC1: bus.exec1       = 1'b1;
      default:  bus.instr_ready = 1'b0;
    endcase
  end

  // Flags, IR' and the retired count only move on handshakes or EXEC1 commits.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ir        <= RESET_IR;
      carry_q   <= 1'b0;
      skip_q    <= 1'b0;
      retired   <= '0;
      proto_err <= 1'b0;
    end else begin
      if (accept) ir <= bus.instr_in;
      if (bus.exec1) begin
        if (bus.carryen) carry_q <= bus.carryout;
        if (bus.skipen)  skip_q  <= bus.skipout;
        retired <= retired + 1'b1;
      end else if (any_en) begin
        proto_err <= 1'b1;
      end
    end
  end

  alu_regfile u_regfile (
    .clk     (clk),
    .reset_n (reset_n),
    .we      (bus.exec1 && bus.wenout),
    .waddr   (ir_f.rd),
    .wdata   (bus.aluout),
    .raddr_a (ir_f.rd),
    .rdata_a (bus.rddata),
    .raddr_b (ir_f.rs),
    .rdata_b (bus.rsdata),
    .raddr_c (dbg_addr),
    .rdata_c (dbg_data)
  );

  assign bus.instruction = ir;
  assign bus.carrystatus = carry_q;
  assign bus.skipstatus  = skip_q;
  assign dbg_state       = state;

endmodule
